// File: rtl/wave_scheduler_pkg.sv
// Shared constants and state type for the waveform scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package wave_pkg;

  localparam int WAVE_W        = 8;    // generator sample width
  localparam int PERIOD_TICKS  = 256;  // advance strobes per full waveform period
  localparam int NUM_WAVES_DEF = 4;    // default size of the generator bank

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    SWITCH
  } sched_state_e;

endpackage

// File: rtl/wave_scheduler_if.sv
// Configuration handshake between top-level control and the scheduler.
// Latency: a valid offer is latched on the edge it is seen while ready is high.
// Backpressure: cfg_ready is low whenever the scheduler is busy; offers are then ignored.
interface wave_scheduler_if #(
  parameter int DIV_W = 16,
  parameter int SEL_W = 2
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [SEL_W-1:0] cfg_sel;
  logic             cfg_auto;
  logic [7:0]       cfg_periods;

  modport master (
    output cfg_valid, cfg_div, cfg_sel, cfg_auto, cfg_periods,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_sel, cfg_auto, cfg_periods,
    output cfg_ready
  );

endinterface

// File: rtl/wave_scheduler_tick_divider.sv
// Reloadable sample-rate divider: tick once every div+1 enabled clocks.
// Latency: tick is combinational from the count register, first tick after div+1 run cycles.
// Backpressure: run low freezes the count; clr forces it back to zero.
module tick_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick = run && (cnt_q == div);

  // Count 0..div while running, reload on the tick, clear on request.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_scheduler.sv
// Sequences a bank of waveform generators onto one shared DAC sample.
// Latency: wave_out/wave_valid update two cycles after the gen_en that produced the sample.
// Backpressure: none on the sample path; configuration only accepted while idle.
module wave_scheduler
  import wave_pkg::*;
#(
  parameter int NUM_WAVES = NUM_WAVES_DEF,
  parameter int SEL_W     = 2,
  parameter int DIV_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  wave_scheduler_if.slave             cfg,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NUM_WAVES*WAVE_W-1:0] wave_in,
  output logic                        gen_en,
  output logic [NUM_WAVES-1:0]        gen_rst,
  output logic [SEL_W-1:0]            sel,
  output logic [WAVE_W-1:0]           wave_out,
  output logic                        wave_valid,
  output logic                        period_done,
  output logic                        busy
);

  localparam logic [7:0]           LAST_TICK = 8'(PERIOD_TICKS - 1);
  localparam logic [NUM_WAVES-1:0] ONE_HOT0  = NUM_WAVES'(1);

  sched_state_e         state_q;
  logic [DIV_W-1:0]     div_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 auto_q;
  logic [7:0]           periods_q;
  logic [7:0]           tick_cnt_q;
  logic [7:0]           per_cnt_q;
  logic [NUM_WAVES-1:0] gen_rst_q;

  logic [SEL_W-1:0]     sel_d1_q;
  logic                 en_d1_q;
  logic [WAVE_W-1:0]    wave_out_q;
  logic                 wave_valid_q;

  logic                 run_en;
  logic                 tick;
  logic                 last_period;
  logic [SEL_W-1:0]     sel_nx;
  logic [WAVE_W-1:0]    wave_arr [NUM_WAVES];

  // A stop cycle suppresses the strobe so the generators freeze where they are.
  assign run_en      = (state_q == RUN) && !stop;
  assign gen_en      = tick;
  assign period_done = tick && (tick_cnt_q == LAST_TICK);
  assign last_period = (per_cnt_q + 8'd1) == periods_q;
  assign sel_nx      = sel_q + SEL_W'(1);

  assign cfg.cfg_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign gen_rst       = gen_rst_q;
  assign sel           = sel_q;
  assign wave_out      = wave_out_q;
  assign wave_valid    = wave_valid_q;

  tick_divider #(.DIV_W(DIV_W)) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != RUN),
    .run  (run_en),
    .div  (div_q),
    .tick (tick)
  );

  // Unpack the generator bus so the sample mux is a plain array index.
  always_comb begin
    for (int i = 0; i < NUM_WAVES; i++) begin
      wave_arr[i] = wave_in[i*WAVE_W +: WAVE_W];
    end
  end

  // Scheduler FSM: config latch, priming, tick/period counting and rotation.
  // gen_rst is registered on the transition so it lines up with PRIME/SWITCH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      sel_q      <= '0;
      auto_q     <= 1'b0;
      periods_q  <= 8'd1;
      tick_cnt_q <= '0;
      per_cnt_q  <= '0;
      gen_rst_q  <= '0;
    end else begin
      gen_rst_q <= '0;
      case (state_q)
        IDLE: begin
          if (cfg.cfg_valid) begin
            div_q     <= cfg.cfg_div;
            sel_q     <= cfg.cfg_sel;
            auto_q    <= cfg.cfg_auto;
            periods_q <= (cfg.cfg_periods == 8'd0) ? 8'd1 : cfg.cfg_periods;
          end
          if (start && !stop) begin
            state_q   <= PRIME;
            gen_rst_q <= ONE_HOT0 << (cfg.cfg_valid ? cfg.cfg_sel : sel_q);
          end
        end
        PRIME: begin
          tick_cnt_q <= '0;
          per_cnt_q  <= '0;
          state_q    <= RUN;
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
            if (period_done && auto_q) begin
              if (last_period) begin
                state_q   <= SWITCH;
                sel_q     <= sel_nx;
                gen_rst_q <= ONE_HOT0 << sel_nx;
              end else begin
                per_cnt_q <= per_cnt_q + 8'd1;
              end
            end
          end
        end
        SWITCH: begin
          tick_cnt_q <= '0;
          per_cnt_q  <= '0;
          state_q    <= stop ? IDLE : RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample path: the generators update on the edge after gen_en, so capture
  // one cycle later using the index that was live when the strobe went out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_d1_q      <= 1'b0;
      sel_d1_q     <= '0;
      wave_out_q   <= '0;
      wave_valid_q <= 1'b0;
    end else begin
      en_d1_q      <= gen_en;
      sel_d1_q     <= sel_q;
      wave_valid_q <= en_d1_q;
      if (en_d1_q) begin
        wave_out_q <= wave_arr[sel_d1_q];
      end
    end
  end

endmodule

// File: tb/tb_wave_scheduler.sv
// Self-checking bench for wave_scheduler with a generator-bank model and an
// arithmetic reference model of the strobe/period/rotation schedule.
module tb_wave_scheduler;

  localparam int NW = 4;
  localparam int SW = 2;
  localparam int DW = 16;
  localparam int TICKS_PER_PERIOD = 256;

  localparam int PH_IDLE   = 0;
  localparam int PH_PRIME  = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_SWITCH = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [NW*8-1:0] wave_in;
  logic            gen_en;
  logic [NW-1:0]   gen_rst;
  logic [SW-1:0]   sel;
  logic [7:0]      wave_out;
  logic            wave_valid;
  logic            period_done;
  logic            busy;

  wave_scheduler_if #(.DIV_W(DW), .SEL_W(SW)) cfg_if ();

  wave_scheduler #(.NUM_WAVES(NW), .SEL_W(SW), .DIV_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_if),
    .start       (start),
    .stop        (stop),
    .wave_in     (wave_in),
    .gen_en      (gen_en),
    .gen_rst     (gen_rst),
    .sel         (sel),
    .wave_out    (wave_out),
    .wave_valid  (wave_valid),
    .period_done (period_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    int         due;
    logic [7:0] val;
  } samp_t;

  int         phase;
  int         m_sel, m_div, m_per, m_k;
  bit         m_auto;
  logic [7:0] m_last;
  logic [7:0] gens [NW];
  int         step_tab [NW] = '{1, 3, 5, 7};
  samp_t      sq [$];
  int         cyc_no;
  bit         chk_on;
  int         n_vec;
  int         n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_no, obs, exp);
    end
  endtask

  task automatic drive_wave();
    for (int i = 0; i < NW; i++) wave_in[i*8 +: 8] = gens[i];
  endtask

  task automatic model_reset();
    phase  = PH_IDLE;
    m_sel  = 0;
    m_div  = 0;
    m_per  = 1;
    m_auto = 1'b0;
    m_k    = 0;
    m_last = 8'h00;
    sq.delete();
  endtask

  // Advance n clock cycles with the inputs currently driven, checking every
  // output against the model in each cycle.
  task automatic cyc(input int n);
    for (int c = 0; c < n; c++) begin
      bit            e_en, e_pd, e_wv, rot;
      int            ticks;
      logic [NW-1:0] e_rst, one;
      logic [7:0]    e_wo, nv;
      #1;
      one   = 1;
      e_en  = (phase == PH_RUN) && !stop && (((m_k + 1) % (m_div + 1)) == 0);
      ticks = (m_k + 1) / (m_div + 1);
      e_pd  = e_en && ((ticks % TICKS_PER_PERIOD) == 0);
      e_rst = (phase == PH_PRIME || phase == PH_SWITCH) ? (one << m_sel) : '0;
      e_wv  = (sq.size() > 0) && (sq[0].due == cyc_no);
      e_wo  = e_wv ? sq[0].val : m_last;
      if (chk_on) begin
        chk("gen_en",      32'(gen_en),           32'(e_en));
        chk("period_done", 32'(period_done),      32'(e_pd));
        chk("gen_rst",     32'(gen_rst),          32'(e_rst));
        chk("sel",         32'(sel),              32'(m_sel));
        chk("busy",        32'(busy),             32'(phase != PH_IDLE));
        chk("cfg_ready",   32'(cfg_if.cfg_ready), 32'(phase == PH_IDLE));
        chk("wave_valid",  32'(wave_valid),       32'(e_wv));
        chk("wave_out",    32'(wave_out),         32'(e_wo));
      end
      if (e_wv) begin
        m_last = e_wo;
        void'(sq.pop_front());
      end
      if (e_en) begin
        nv = gens[m_sel] + 8'(step_tab[m_sel]);
        sq.push_back('{cyc_no + 2, nv});
      end
      for (int i = 0; i < NW; i++) begin
        if (e_rst[i]) gens[i] = 8'h00;
        else if (e_en) gens[i] = gens[i] + 8'(step_tab[i]);
      end
      rot = m_auto && e_en && (ticks == m_per * TICKS_PER_PERIOD);
      if (!rst) begin
        model_reset();
      end else begin
        case (phase)
          PH_IDLE: begin
            if (cfg_if.cfg_valid) begin
              m_div  = int'(cfg_if.cfg_div);
              m_sel  = int'(cfg_if.cfg_sel);
              m_auto = cfg_if.cfg_auto;
              m_per  = (cfg_if.cfg_periods == 8'd0) ? 1 : int'(cfg_if.cfg_periods);
            end
            if (start && !stop) phase = PH_PRIME;
          end
          PH_PRIME: begin
            phase = PH_RUN;
            m_k   = 0;
          end
          PH_RUN: begin
            if (stop) phase = PH_IDLE;
            else if (rot) begin
              phase = PH_SWITCH;
              m_sel = (m_sel + 1) % NW;
            end else m_k++;
          end
          default: begin
            m_k   = 0;
            phase = stop ? PH_IDLE : PH_RUN;
          end
        endcase
      end
      @(posedge clk);
      #1;
      cyc_no++;
      drive_wave();
    end
  endtask

  task automatic set_cfg(input int div, input int s, input bit au, input int per);
    cfg_if.cfg_div     = DW'(div);
    cfg_if.cfg_sel     = SW'(s);
    cfg_if.cfg_auto    = au;
    cfg_if.cfg_periods = 8'(per);
  endtask

  // Offer a configuration and start in the same cycle, then return to idle inputs.
  task automatic cfg_start(input int div, input int s, input bit au, input int per);
    set_cfg(div, s, au, per);
    cfg_if.cfg_valid = 1'b1;
    start = 1'b1;
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(4);
  endtask

  initial begin
    int d;
    n_vec  = 0;
    n_err  = 0;
    cyc_no = 0;
    chk_on = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    set_cfg(0, 0, 1'b0, 0);
    for (int i = 0; i < NW; i++) gens[i] = 8'($urandom);
    drive_wave();
    model_reset();

    // Reset, then observe the idle state while reset is still held.
    rst = 1'b0;
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Config div=3 sel=2 no rotation, start in a separate cycle.
    set_cfg(3, 2, 1'b0, $urandom_range(0, 255));
    cfg_if.cfg_valid = 1'b1;
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(40);
    do_stop();

    // Full-rate run across two period boundaries.
    cfg_start(0, $urandom_range(0, NW - 1), 1'b0, 1);
    cyc(600);
    do_stop();

    // Rotation every period from generator 3, four full rotations.
    cfg_start(0, 3, 1'b1, 1);
    cyc(4 * (TICKS_PER_PERIOD + 1) + 12);
    do_stop();

    // Stop exactly on a strobe-eligible cycle, then reconfigure while idle.
    d = $urandom_range(1, 4);
    cfg_start(d, $urandom_range(0, NW - 1), 1'b0, 1);
    cyc(1 + 2 * d + 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    set_cfg($urandom_range(0, 5), $urandom_range(0, NW - 1), 1'b0, 1);
    cfg_if.cfg_valid = 1'b1;
    cyc(1);
    cfg_if.cfg_valid = 1'b0;
    cyc(3);

    // start and stop together while idle: nothing happens.
    start = 1'b1;
    stop  = 1'b1;
    cyc(3);
    start = 1'b0;
    stop  = 1'b0;
    cyc(2);

    // periods=0 behaves as one period per generator.
    cfg_start(0, $urandom_range(0, NW - 1), 1'b1, 0);
    cyc(2 * (TICKS_PER_PERIOD + 1) + 20);
    do_stop();

    // Reset asserted during SWITCH.
    cfg_start(0, $urandom_range(0, NW - 1), 1'b1, 0);
    cyc(1 + TICKS_PER_PERIOD);
    rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(4);

    // Randomised runs with ignored configuration noise while busy.
    for (int it = 0; it < 6; it++) begin
      int len;
      set_cfg($urandom_range(0, 2), $urandom_range(0, NW - 1), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
      cfg_if.cfg_valid = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        cyc(1);
      end else begin
        cyc(1);
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        cyc(1);
      end
      start = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      len = $urandom_range(100, 1500);
      for (int c = 0; c < len; c++) begin
        cfg_if.cfg_valid = ($urandom_range(0, 7) == 0);
        set_cfg($urandom_range(0, 7), $urandom_range(0, NW - 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3));
        cyc(1);
      end
      cfg_if.cfg_valid = 1'b0;
      do_stop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wave_scheduler.md
Name: wave_scheduler

Overview:
- Sequences the lab's 8-bit waveform generators (rhomboid, triangle, sawtooth, square and the like) that sit behind a shared DAC output.
- Produces the generators' advance strobe at a programmable sample rate and selects one generator's sample onto the shared output.
- Optionally rotates through the generators automatically after a programmed number of full periods, resetting each incoming generator so its period starts clean.
- Sits between the top-level control (switches/buttons or testbench) and the generator bank.

Parameters:
- NUM_WAVES, 4: number of generator inputs. Power of two, at least 2.
- SEL_W, 2: log2(NUM_WAVES).
- DIV_W, 16: width of the sample-rate divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted (high only in IDLE).
- cfg_div  in  DIV_W  sample tick every cfg_div+1 clocks.
- cfg_sel  in  SEL_W  initial generator index.
- cfg_auto  in  1  enable automatic rotation.
- cfg_periods  in  8  periods per generator before rotating; 0 is treated as 1.
- start  in  1  begin running with the latched configuration.
- stop  in  1  halt.
- wave_in  in  NUM_WAVES*8  packed generator samples; generator i occupies bits [8i+7:8i].
- gen_en  out  1  one-cycle advance strobe to all generators.
- gen_rst  out  NUM_WAVES  active-high one-cycle reset per generator.
- sel  out  SEL_W  current generator index.
- wave_out  out  8  registered selected sample.
- wave_valid  out  1  one-cycle pulse when wave_out updates.
- period_done  out  1  one-cycle pulse at each completed 256-tick period.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (rst=0 at a clk edge) returns every output to zero and the FSM to IDLE. Zeroed state:
  - cfg_ready=1 (IDLE).
  - gen_en=0, gen_rst=0, sel=0, wave_out=0, wave_valid=0, period_done=0, busy=0.
  - Latched configuration: div=0, sel=0, auto=0, periods=1.
- Reset mid-run aborts immediately. No gen_rst pulse is issued.
- FSM states are IDLE, PRIME, RUN, SWITCH.
- IDLE:
  - cfg_ready=1. On cfg_valid, latch all cfg_* fields; sel takes cfg_sel.
  - If start=1 and stop=0: go to PRIME. When cfg_valid and start arrive together, the new configuration is used.
  - start and stop together: stay in IDLE (stop wins).
- PRIME (1 cycle):
  - gen_rst[sel]=1. Clear the divider, the tick counter (8-bit) and the period counter.
  - Next state is RUN.
- RUN:
  - Divider counts 0..div. At count==div, gen_en=1 for that cycle and the divider reloads to 0.
  - div=0 gives gen_en every cycle.
  - Each gen_en increments the tick counter. When the counter wraps 255->0, period_done pulses in the same cycle as that gen_en.
  - If auto=1, the period counter increments on each period_done. When it reaches periods, go to SWITCH.
  - stop=1 goes to IDLE next cycle. No gen_en is issued in the stop cycle. wave_out holds its last value.
- SWITCH (1 cycle):
  - sel <= sel+1 modulo NUM_WAVES.
  - gen_rst for the new index is asserted this cycle.
  - Divider, tick counter and period counter clear.
  - Next state is RUN. stop during SWITCH goes to IDLE, with sel already advanced.
- Sample path latency:
  - Generators register their output on the edge ending the gen_en cycle T.
  - The scheduler registers wave_in[sel] on the edge ending cycle T+1.
  - wave_out is new and wave_valid=1 in cycle T+2.
  - Exactly one wave_valid per gen_en, including gen_en strobes issued just before stop.
- busy=1 in PRIME, RUN and SWITCH.
- Divider comparison is unsigned at DIV_W width. No other arithmetic beyond modulo wrap.

Decomposition:
- Shared package wave_pkg holds:
  - WAVE_W=8 and PERIOD_TICKS=256.
  - The scheduler state enum (IDLE, PRIME, RUN, SWITCH).
  - The default NUM_WAVES.
- One natural sub-module, tick_divider: a DIV_W-bit reloadable counter with inputs clr, div and run, and a tick output. wave_scheduler instantiates it.

Test Plan:
- Reset then idle: outputs are all zero and cfg_ready=1. Config div=3, sel=2, auto=0, then start. Required: gen_rst=4'b0100 for 1 cycle, then gen_en every 4th cycle, sel=2, and wave_out equals wave_in[23:16] two cycles after each gen_en.
- div=0, auto=0, run 600 cycles. Required: gen_en high every RUN cycle, period_done pulses exactly on ticks 256 and 512, and wave_valid count equals gen_en count.
- auto=1, periods=1, div=0, sel=3. Required: after 256 ticks, SWITCH makes sel=0 with gen_rst=4'b0001, and after 4 rotations sel returns to 3.
- Apply stop mid-RUN together with a gen_en-eligible cycle. Required: no gen_en, FSM reaches IDLE next cycle, busy=0, wave_out holds, and a new cfg is accepted.
- Assert start and stop together in IDLE. Required: stays IDLE with no gen_rst.
- Assert rst=0 during SWITCH. Required: all outputs zero next cycle.
- cfg_periods=0, auto=1. Required: rotation occurs after 1 period.
